// File: rtl/cache_arbiter.sv
// Round-robin arbiter sharing one line-wide memory port between the icache and dcache.
// The winner's command is registered, one memory transaction runs, and only the winner sees resp.
module cache_arbiter #(
   parameter int s_line  = 256,
   parameter int timeout = 1024
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              i_read,
   input  logic              i_write,
   input  logic [31:0]       i_address,
   input  logic [s_line-1:0] i_wdata,
   output logic [s_line-1:0] i_rdata,
   output logic              i_resp,
   input  logic              d_read,
   input  logic              d_write,
   input  logic [31:0]       d_address,
   input  logic [s_line-1:0] d_wdata,
   output logic [s_line-1:0] d_rdata,
   output logic              d_resp,
   output logic              mem_read,
   output logic              mem_write,
   output logic [31:0]       mem_address,
   output logic [s_line-1:0] mem_wdata,
   input  logic [s_line-1:0] mem_rdata,
   input  logic              mem_resp,
   output logic              err_timeout,
   output logic              err_protocol
);
   localparam int CW = $clog2(timeout);
   localparam logic [CW-1:0] T_MAX = CW'(timeout - 1);
   localparam logic [CW-1:0] T_ERR = CW'(timeout - 2);

   typedef enum logic [1:0] {IDLE = 2'd0, MEM = 2'd1, DONE = 2'd2} state_t;

   state_t            state_q;
   logic              last_q;      // 1'b1 = dcache served last
   logic              owner_q;     // 1'b1 = dcache owns the transaction
   logic [31:0]       addr_q;
   logic [s_line-1:0] wdata_q;
   logic [s_line-1:0] rdata_q;
   logic              mem_read_q;
   logic              mem_write_q;
   logic              i_resp_q;
   logic              d_resp_q;
   logic              err_to_q;
   logic              err_pr_q;
   logic [CW-1:0]     cnt_q;

   logic              i_pend_s;
   logic              d_pend_s;
   logic              gnt_s;
   logic              proto_s;
   logic              owner_d;
   logic              wr_d;
   logic [31:0]       addr_d;
   logic [s_line-1:0] wdata_d;

   // Grant selection and the winner's command; a read+write collision is treated as a write.
   always_comb begin
      i_pend_s = i_read | i_write;
      d_pend_s = d_read | d_write;
      gnt_s    = i_pend_s | d_pend_s;
      proto_s  = (i_read & i_write) | (d_read & d_write);
      if (i_pend_s && d_pend_s) begin
         owner_d = ~last_q;
      end else if (d_pend_s) begin
         owner_d = 1'b1;
      end else begin
         owner_d = 1'b0;
      end
      if (owner_d) begin
         addr_d  = d_address;
         wdata_d = d_wdata;
         wr_d    = d_write;
      end else begin
         addr_d  = i_address;
         wdata_d = i_wdata;
         wr_d    = i_write;
      end
   end

   // Arbitration FSM with registered memory command, response and sticky error flags.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= IDLE;
         last_q      <= 1'b1;
         owner_q     <= 1'b0;
         addr_q      <= 32'h0;
         wdata_q     <= '0;
         rdata_q     <= '0;
         mem_read_q  <= 1'b0;
         mem_write_q <= 1'b0;
         i_resp_q    <= 1'b0;
         d_resp_q    <= 1'b0;
         err_to_q    <= 1'b0;
         err_pr_q    <= 1'b0;
         cnt_q       <= '0;
      end else begin
         if (proto_s) begin
            err_pr_q <= 1'b1;
         end
         case (state_q)
            IDLE: begin
               if (gnt_s) begin
                  owner_q     <= owner_d;
                  last_q      <= owner_d;
                  addr_q      <= addr_d;
                  wdata_q     <= wdata_d;
                  mem_read_q  <= ~wr_d;
                  mem_write_q <= wr_d;
                  cnt_q       <= '0;
                  state_q     <= MEM;
               end
            end
            MEM: begin
               if (mem_resp) begin
                  rdata_q     <= mem_rdata;
                  mem_read_q  <= 1'b0;
                  mem_write_q <= 1'b0;
                  i_resp_q    <= ~owner_q;
                  d_resp_q    <= owner_q;
                  state_q     <= DONE;
               end else begin
                  // The flag appears in the same cycle the counter shows timeout-1.
                  if (cnt_q == T_ERR) begin
                     err_to_q <= 1'b1;
                  end
                  if (cnt_q != T_MAX) begin
                     cnt_q <= cnt_q + CW'(1);
                  end
               end
            end
            DONE: begin
               i_resp_q <= 1'b0;
               d_resp_q <= 1'b0;
               state_q  <= IDLE;
            end
            default: begin
               mem_read_q  <= 1'b0;
               mem_write_q <= 1'b0;
               i_resp_q    <= 1'b0;
               d_resp_q    <= 1'b0;
               state_q     <= IDLE;
            end
         endcase
      end
   end

   assign i_rdata      = rdata_q;
   assign d_rdata      = rdata_q;
   assign i_resp       = i_resp_q;
   assign d_resp       = d_resp_q;
   assign mem_read     = mem_read_q;
   assign mem_write    = mem_write_q;
   assign mem_address  = addr_q;
   assign mem_wdata    = wdata_q;
   assign err_timeout  = err_to_q;
   assign err_protocol = err_pr_q;
endmodule
